shift_add_multiplier: RTL and testbench

//  Sequential signed/unsigned shift-and-add multiplier datapath that responds to the multiply control FSM.
//  - load_data captures the operands.
//  - shift_en advances one iteration per cycle; extend selects two's-complement interpretation.
//  - Asserts mult_done when the product is valid.
//  - Sits between the operand switches/registers and the seven-segment scroll display.

---
 rtl/shift_add_multiplier_if.sv | 24 ++
 rtl/shift_add_multiplier.sv | 106 ++++++++++
 tb/tb_shift_add_multiplier.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Operand/control and result bundle for the shift-and-add multiplier.
// The master side drives operands and control; the slave side is the datapath.
interface shift_add_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 load_data;
   logic                 shift_en;
   logic                 extend;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   product;
   logic                 mult_done;
   logic                 busy;

   modport master (
      output load_data, shift_en, extend, multiplicand, multiplier,
      input  product, mult_done, busy
   );

   modport slave (
      input  load_data, shift_en, extend, multiplicand, multiplier,
      output product, mult_done, busy
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential signed/unsigned shift-and-add multiplier, one iteration per shift_en cycle.
// Define EARLY_TERM_EN to leave RUN as soon as the remaining multiplier magnitude is zero.
//
// state | meaning
// IDLE  | waiting for load_data
// PREP  | convert captured operands to magnitudes, latch result sign
// RUN   | one conditional add and shift per enabled cycle
// FIN   | apply sign and register the product
// DONE  | product valid, held until next load_data
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   shift_add_multiplier_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PREP, RUN, FIN, DONE} state_t;

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   state_t               state;
   state_t               state_nxt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   product_r;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic                 sign;
   logic [CW-1:0]        count;
   logic                 last_step;
   logic                 prep_to_fin;

   // Operands sit raw in mcand/mplier until PREP turns them into magnitudes
   always_comb begin
      mag_a       = (bus.extend && mcand[WIDTH-1]) ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0];
      mag_b       = (bus.extend && mplier[WIDTH-1]) ? -mplier : mplier;
      last_step   = (count == LAST) || (EARLY_TERM && (mplier[WIDTH-1:1] == '0));
      prep_to_fin = EARLY_TERM && (mplier == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.load_data) begin
         state_nxt = PREP;
      end else if (bus.shift_en) begin
         case (state)
            PREP:    state_nxt = prep_to_fin ? FIN : RUN;
            RUN:     if (last_step) state_nxt = FIN;
            FIN:     state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         sign      <= 1'b0;
         count     <= '0;
         product_r <= '0;
      end else if (bus.load_data) begin
         mcand  <= {{WIDTH{1'b0}}, bus.multiplicand};
         mplier <= bus.multiplier;
         acc    <= '0;
         count  <= '0;
         sign   <= 1'b0;
      end else if (bus.shift_en) begin
         case (state)
            PREP: begin
               mcand  <= {{WIDTH{1'b0}}, mag_a};
               mplier <= mag_b;
               sign   <= bus.extend & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
               acc    <= '0;
               count  <= '0;
            end
            RUN: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
            end
            FIN: product_r <= sign ? -acc : acc;
            default: ;
         endcase
      end
   end

   assign bus.product   = product_r;
   assign bus.mult_done = (state == DONE);
   assign bus.busy      = (state == PREP) || (state == RUN) || (state == FIN);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier; expected products are queued at load
// and popped when mult_done rises.
module tb_shift_add_multiplier;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();
   shift_add_multiplier #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [2*WIDTH-1:0] exp_q[$];
   logic [2*WIDTH-1:0] last_product = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic ext);
      int sa;
      int sb;
      sa = ext ? int'($signed(a)) : int'(a);
      sb = ext ? int'($signed(b)) : int'(b);
      return (2*WIDTH)'(sa * sb);
   endfunction

   // Cycles from load edge to mult_done visible, shift_en held high.
   function automatic int exp_latency(input logic [WIDTH-1:0] b, input logic ext);
`ifdef EARLY_TERM_EN
      logic [WIDTH-1:0] mag;
      int steps;
      mag   = (ext && b[WIDTH-1]) ? -b : b;
      steps = 0;
      for (int i = 0; i < WIDTH; i++) if (mag[i]) steps = i + 1;
      // zero multiplier: PREP -> FIN -> DONE
      return (steps == 0) ? 2 : steps + 2;
`else
      return WIDTH + 2;
`endif
   endfunction

   task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ext, input bit push);
      @(negedge clk);
      bus.load_data    = 1'b1;
      bus.shift_en     = 1'b1;
      bus.extend       = ext;
      bus.multiplicand = a;
      bus.multiplier   = b;
      if (push) exp_q.push_back(model(a, b, ext));
      @(negedge clk);
      bus.load_data = 1'b0;
      chk("busy_after_load", 32'(bus.busy), 32'd1);
      chk("done_clear_after_load", 32'(bus.mult_done), 32'd0);
      chk("product_held_at_load", 32'(bus.product), 32'(last_product));
   endtask

   task automatic wait_done(input int exp_lat, input int stall_at, input int stall_len);
      int cyc;
      bit got;
      logic [2*WIDTH-1:0] exp;
      cyc = 0;
      got = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         cyc = i;
         if (bus.mult_done) begin
            got = 1'b1;
            break;
         end
         chk("busy_while_running", 32'(bus.busy), 32'd1);
         chk("product_hold_running", 32'(bus.product), 32'(last_product));
         bus.shift_en = !(i >= stall_at && i < stall_at + stall_len);
      end
      bus.shift_en = 1'b1;
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (got) begin
         chk("product", 32'(bus.product), 32'(exp));
         chk("busy_cleared_at_done", 32'(bus.busy), 32'd0);
         last_product = bus.product;
      end
   endtask

   initial begin
      bus.load_data    = 1'b1;
      bus.shift_en     = 1'b1;
      bus.extend       = 1'b1;
      bus.multiplicand = 8'h55;
      bus.multiplier   = 8'hAA;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_product", 32'(bus.product), 32'd0);
      chk("reset_done", 32'(bus.mult_done), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.load_data = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_ignores_shift", 32'(bus.busy), 32'd0);

      start(8'd3, 8'd4, 1'b1, 1'b1);
      wait_done(exp_latency(8'd4, 1'b1), 0, 0);
      start(8'h80, 8'h80, 1'b1, 1'b1);
      wait_done(exp_latency(8'h80, 1'b1), 0, 0);
      start(8'hFD, 8'd7, 1'b1, 1'b1);
      wait_done(exp_latency(8'd7, 1'b1), 0, 0);
      start(8'hFD, 8'd7, 1'b0, 1'b1);
      wait_done(exp_latency(8'd7, 1'b0), 0, 0);
      start(8'd0, 8'hFF, 1'b0, 1'b1);
      wait_done(exp_latency(8'hFF, 1'b0), 0, 0);
      start(8'h7F, 8'h80, 1'b1, 1'b1);
      wait_done(exp_latency(8'h80, 1'b1), 0, 0);
      start(8'hFF, 8'hFF, 1'b0, 1'b1);
      wait_done(exp_latency(8'hFF, 1'b0), 0, 0);
      start(8'hFD, 8'd0, 1'b1, 1'b1);
      wait_done(exp_latency(8'd0, 1'b1), 0, 0);

      // stall three cycles in the middle of RUN
      start(8'd5, 8'd6, 1'b0, 1'b1);
      wait_done(exp_latency(8'd6, 1'b0) + 3, 4, 3);

      // abort 9*9 at RUN step 3 with a new load
      start(8'd9, 8'd9, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", 32'(bus.mult_done), 32'd0);
         chk("abort_product_hold", 32'(bus.product), 32'(last_product));
      end
      start(8'd2, 8'hFE, 1'b1, 1'b1);
      wait_done(exp_latency(8'hFE, 1'b1), 0, 0);

      // reset in the middle of RUN
      start(8'd5, 8'd6, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_product", 32'(bus.product), 32'd0);
      chk("rst_mid_done", 32'(bus.mult_done), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_product = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stays_idle", 32'(bus.busy), 32'd0);

      start(8'd3, 8'd4, 1'b1, 1'b1);
      wait_done(exp_latency(8'd4, 1'b1), 0, 0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
